// File: rtl/program_loader.sv
// program_loader: front-panel program loader and program memory for the DE0 CPU shell.
//
// In program mode every debounced press of the program-clock button stores the
// switch byte at the next sequential address, starting at 0. In run mode the
// loader is idle and the CPU fetches through a registered read port.
//
// Ports:
//   clock      system clock, all state on the rising edge
//   reset_N    asynchronous active-low reset (memory contents are not reset)
//   mode       raw switch, 1 = program mode, 0 = run mode
//   p_clock_N  raw push button, active low
//   io_in      raw switch byte to be written
//   cpu_addr   CPU instruction fetch address
//   cpu_data   registered mem[cpu_addr], one cycle latency
//   load_addr  next address to be written
//   wr_strobe  one-cycle pulse after each memory write
//   full       last address has been written
//   overflow   sticky, a press was accepted while full
module program_loader #(
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_N,
    input  logic                  mode,
    input  logic                  p_clock_N,
    input  logic [7:0]            io_in,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [7:0]            cpu_data,
    output logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  wr_strobe,
    output logic                  full,
    output logic                  overflow
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

    typedef enum logic [1:0] {StIdle, StArmed, StPressed, StWaitRel} state_e;

    state_e                  state_q, state_d;
    logic                    mode_s1, mode_s2;
    logic                    btn_s1, btn_s2;
    logic                    btn_db;
    logic [7:0]              io_q;
    logic [ADDR_WIDTH-1:0]   load_addr_q, load_addr_d;
    logic                    full_q, full_d;
    logic                    overflow_q, overflow_d;
    logic                    wr_strobe_q;
    logic                    mem_we;
    logic [7:0]              cpu_data_q;
    logic [7:0]              mem [Depth];

    // Input conditioning: 2-FF synchronizers for mode and button, one stage for data.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            btn_s1  <= 1'b1;
            btn_s2  <= 1'b1;
            io_q    <= '0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            btn_s1  <= p_clock_N;
            btn_s2  <= btn_s1;
            io_q    <= io_in;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            always_ff @(posedge clock or negedge reset_N) begin
                if (!reset_N) btn_db <= 1'b1;
                else          btn_db <= btn_s2;
            end
        end else begin : g_debounce
            logic [CntW-1:0] db_cnt_q;

            // The count only advances while the synced level disagrees with the
            // accepted level; any agreement (a bounce) restarts it.
            always_ff @(posedge clock or negedge reset_N) begin
                if (!reset_N) begin
                    btn_db   <= 1'b1;
                    db_cnt_q <= '0;
                end else if (btn_s2 == btn_db) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db   <= btn_s2;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= StIdle;
            load_addr_q <= '0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            wr_strobe_q <= mem_we;
        end
    end

    // ARMED is only entered with the debounced level high, so a low level seen
    // there is the 1->0 press edge.
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        full_d      = full_q;
        overflow_d  = overflow_q;
        mem_we      = 1'b0;
        if (!mode_s2) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    load_addr_d = '0;
                    full_d      = 1'b0;
                    overflow_d  = 1'b0;
                    // A button already held on entry must be released first.
                    state_d     = btn_db ? StArmed : StWaitRel;
                end
                StArmed: begin
                    if (!btn_db) begin
                        state_d = StPressed;
                        if (full_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                            if (load_addr_q == LastAddr) full_d = 1'b1;
                            else                         load_addr_d = load_addr_q + 1'b1;
                        end
                    end
                end
                StPressed: if (btn_db) state_d = StArmed;
                StWaitRel: if (btn_db) state_d = StArmed;
                default:   state_d = StIdle;
            endcase
        end
    end

    // Program memory is deliberately left out of reset so a run-mode reset keeps the program.
    always_ff @(posedge clock) begin
        if (mem_we) mem[load_addr_q] <= io_q;
    end

    // Read-before-write: a same-cycle write to cpu_addr returns the old byte.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) cpu_data_q <= '0;
        else          cpu_data_q <= mem[cpu_addr];
    end

    assign cpu_data  = cpu_data_q;
    assign load_addr = load_addr_q;
    assign wr_strobe = wr_strobe_q;
    assign full      = full_q;
    assign overflow  = overflow_q;

endmodule
